fifo36_wrr_sched: RTL and testbench
===================================

Name: fifo36_wrr_sched

Overview:
- Packet-aware weighted round-robin scheduler merging three fifo36 streams into one fifo36 output.
- Grants whole packets (SOF..EOF) so packets never interleave.
- Each input may send up to weightN back-to-back packets per turn, then the grant rotates.
- Sits ahead of the Ethernet/VITA TX path, where control, data and status streams share one egress FIFO.

Parameters:
- WEIGHT_W, 4, width of each per-input weight and of the internal credit counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous, active-high flush; identical effect to reset
- weight0  in  WEIGHT_W  max consecutive packets for input 0; 0 disables input 0
- weight1  in  WEIGHT_W  same, input 1
- weight2  in  WEIGHT_W  same, input 2
- data0_i  in  36  input 0 fifo36 word ([32]=SOF, [33]=EOF, [35:34]=occupancy)
- src0_rdy_i  in  1  input 0 valid
- dst0_rdy_o  out  1  input 0 accept
- data1_i, src1_rdy_i, dst1_rdy_o  in/in/out  36/1/1  input 1, same semantics
- data2_i, src2_rdy_i, dst2_rdy_o  in/in/out  36/1/1  input 2, same semantics
- data_o  out  36  merged output word
- src_rdy_o  out  1  output valid
- dst_rdy_i  in  1  downstream accept
- active_o  out  1  high while a packet is granted
- grant_o  out  2  index of the granted or last-granted input (0..2)

Behaviour:
- Transfer rule: a beat transfers on a port when its src_rdy and dst_rdy are both high on a rising clk edge.

State machine:
- Two states: IDLE and ACTIVE.
- Registers:
  - state
  - sel[1:0], the granted input
  - last[1:0], the previously granted input
  - credit[WEIGHT_W-1:0]

Reset or clear:
- state=IDLE, sel=0, last=2 (so input 0 wins the first scan), credit=0.
- All outputs low: data_o=0, src_rdy_o=0, dst*_rdy_o=0, active_o=0, grant_o=0.
- Reset or clear mid-packet abandons the packet; no EOF is synthesized. Upstream is flushed by the same clear.

Eligibility:
- Input i is eligible when srci_rdy_i=1 and weighti != 0.

IDLE, evaluated each cycle (priority order):
1. Continue: if credit != 0 and input last is eligible, then sel<=last, credit<=credit-1, go ACTIVE.
2. Otherwise rotate: scan last+1, last+2, last (mod 3) and take the first eligible input k. Then sel<=k, credit<=weightk-1, go ACTIVE.
3. Otherwise stay IDLE.

ACTIVE:
- Combinational datapath, zero latency:
  - data_o = data_i[sel]
  - src_rdy_o = src_rdy_i[sel]
  - dst_rdy_o[sel] = dst_rdy_i
  - the other two dst*_rdy_o = 0
- On a transfer with EOF (data_o[33]=1): last<=sel, go IDLE.
- The SOF bit is not checked. The scheduler trusts upstream framing.

Timing:
- Exactly one bubble cycle (IDLE) between consecutive packets.
- Grant is visible the cycle after the IDLE decision.

In IDLE:
- src_rdy_o=0, all dst*_rdy_o=0, data_o=0.

Status outputs:
- active_o = (state==ACTIVE).
- grant_o = sel.

Weights:
- Sampled only at grant time. Changes mid-packet take effect at the next IDLE decision.
- Weight 0 on an input that is currently mid-packet does not truncate that packet.

Boundary conditions:
- Single requester: re-granted every packet via the rotate scan (last has lowest priority but is still included), with credit reloaded.
- weight=1: credit loads 0, so the grant rotates after every packet when others are eligible.
- Credit is not decremented in ACTIVE. It counts packets, not beats.
- A single-beat packet (SOF and EOF in one word) occupies one ACTIVE cycle plus one IDLE cycle.
- src_rdy_i deasserting mid-packet stalls the output. The grant is held indefinitely until EOF; there is no timeout.
- Credit arithmetic is unsigned WEIGHT_W-bit. The decrement only occurs when credit != 0, so the counter never wraps.

Decomposition:
- Shared package:
  - fifo36 bit positions: SOF=32, EOF=33, OCC=35:34
  - state encoding localparams
  - 2-bit port-index type
- One natural sub-module: rr_pick3. Combinational; takes (last, eligible[2:0]) and returns (found, idx) in round-robin order.
- The FSM, credit counter and output mux stay in the top.

Test Plan:
- Reset then weights 1/1/1, all inputs continuously ready with 3-beat packets (SOF on beat 0, EOF on beat 2) -> grant order 0,1,2,0,... Each packet is 3 ACTIVE cycles followed by 1 IDLE cycle, and there is no interleaving.
- Weights 3/1/1, all ready -> output packet sources 0,0,0,1,2,0,0,0,1,2.
- Only input 1 ready, weight1=2, weights 0/2 -> input 1 re-granted every packet; grant_o stays 1 and active_o pulses low 1 cycle between packets.
- Weight2=0, input 2 ready alongside input 0 (weight 1) -> input 2 is never granted and dst2_rdy_o stays 0.
- Hold dst_rdy_i=0 for 5 cycles mid-packet on input 0 -> data_o is held stable, no beat is lost or duplicated, and the grant does not change.
- Assert clear for 1 cycle on beat 2 of a 4-beat packet -> next cycle active_o=0 and src_rdy_o=0; the next grant goes to input 0 (last=2).

Source files
------------

// File: rtl/fifo36_wrr_sched_pkg.sv
// Shared definitions for the fifo36 weighted round-robin scheduler:
// fifo36 framing bit positions, FSM encoding and the input-port index type.
package fifo36_wrr_sched_pkg;

   localparam int SOF_BIT = 32;
   localparam int EOF_BIT = 33;
   localparam int OCC_MSB = 35;
   localparam int OCC_LSB = 34;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACTIVE = 1'b1;

   typedef enum logic {
      IDLE   = ST_IDLE,
      ACTIVE = ST_ACTIVE
   } state_t;

   typedef logic [1:0] port_idx_t;

   // Successor of an input index in the ring 0 -> 1 -> 2 -> 0.
   function automatic port_idx_t next_idx(input port_idx_t i);
      return (i == 2'd2) ? 2'd0 : port_idx_t'(i + 2'd1);
   endfunction

   function automatic logic bit_at(input logic [2:0] v, input port_idx_t i);
      case (i)
         2'd0:    return v[0];
         2'd1:    return v[1];
         2'd2:    return v[2];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fifo36_wrr_sched_rr_pick3.sv
// Round-robin picker over three requesters: scans last+1, last+2, last and
// returns the first eligible index.
module fifo36_wrr_sched_rr_pick3
   import fifo36_wrr_sched_pkg::*;
(
   input  port_idx_t  last,
   input  logic [2:0] eligible,
   output logic       found,
   output port_idx_t  idx
);

   port_idx_t cand1;
   port_idx_t cand2;

   assign cand1 = next_idx(last);
   assign cand2 = next_idx(cand1);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else chain leaves a value unassigned (no latch).
   always_comb begin
      found = 1'b1;
      idx   = last;
      if (bit_at(eligible, cand1))      idx = cand1;
      else if (bit_at(eligible, cand2)) idx = cand2;
      else if (bit_at(eligible, last))  idx = last;
      else                              found = 1'b0;
   end

endmodule

// File: rtl/fifo36_wrr_sched.sv
// Packet-aware weighted round-robin merge of three fifo36 streams into one;
// whole packets are granted and an input may keep the grant for weightN packets.
module fifo36_wrr_sched
   import fifo36_wrr_sched_pkg::*;
#(
   parameter int WEIGHT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic [WEIGHT_W-1:0] weight0,
   input  logic [WEIGHT_W-1:0] weight1,
   input  logic [WEIGHT_W-1:0] weight2,
   input  logic [35:0]         data0_i,
   input  logic                src0_rdy_i,
   output logic                dst0_rdy_o,
   input  logic [35:0]         data1_i,
   input  logic                src1_rdy_i,
   output logic                dst1_rdy_o,
   input  logic [35:0]         data2_i,
   input  logic                src2_rdy_i,
   output logic                dst2_rdy_o,
   output logic [35:0]         data_o,
   output logic                src_rdy_o,
   input  logic                dst_rdy_i,
   output logic                active_o,
   output logic [1:0]          grant_o
);

   state_t              state, state_nx;
   port_idx_t           sel, sel_nx;
   port_idx_t           last, last_nx;
   logic [WEIGHT_W-1:0] credit, credit_nx;

   logic [2:0]          eligible;
   logic                pick_found;
   port_idx_t           pick_idx;
   logic [WEIGHT_W-1:0] pick_weight;
   logic                xfer_eof;

   assign eligible = {src2_rdy_i & (weight2 != '0),
                      src1_rdy_i & (weight1 != '0),
                      src0_rdy_i & (weight0 != '0)};

   fifo36_wrr_sched_rr_pick3 u_pick (
      .last     (last),
      .eligible (eligible),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   always_comb begin
      case (pick_idx)
         2'd0:    pick_weight = weight0;
         2'd1:    pick_weight = weight1;
         default: pick_weight = weight2;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state  <= IDLE;
         sel    <= 2'd0;
         last   <= 2'd2;
         credit <= '0;
      end else begin
         state  <= state_nx;
         sel    <= sel_nx;
         last   <= last_nx;
         credit <= credit_nx;
      end
   end

   // Credit counts packets: it moves only on IDLE decisions, never per beat.
   always_comb begin
      state_nx  = state;
      sel_nx    = sel;
      last_nx   = last;
      credit_nx = credit;
      case (state)
         IDLE: begin
            if ((credit != '0) && bit_at(eligible, last)) begin
               sel_nx    = last;
               credit_nx = credit - WEIGHT_W'(1);
               state_nx  = ACTIVE;
            end else if (pick_found) begin
               sel_nx    = pick_idx;
               credit_nx = pick_weight - WEIGHT_W'(1);
               state_nx  = ACTIVE;
            end
         end
         ACTIVE: begin
            if (xfer_eof) begin
               last_nx  = sel;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      data_o     = '0;
      src_rdy_o  = 1'b0;
      dst0_rdy_o = 1'b0;
      dst1_rdy_o = 1'b0;
      dst2_rdy_o = 1'b0;
      if (state == ACTIVE) begin
         case (sel)
            2'd0: begin
               data_o     = data0_i;
               src_rdy_o  = src0_rdy_i;
               dst0_rdy_o = dst_rdy_i;
            end
            2'd1: begin
               data_o     = data1_i;
               src_rdy_o  = src1_rdy_i;
               dst1_rdy_o = dst_rdy_i;
            end
            2'd2: begin
               data_o     = data2_i;
               src_rdy_o  = src2_rdy_i;
               dst2_rdy_o = dst_rdy_i;
            end
            default: ;
         endcase
      end
   end

   assign xfer_eof = src_rdy_o & dst_rdy_i & data_o[EOF_BIT];
   assign active_o = (state == ACTIVE);
   assign grant_o  = sel;

endmodule

// File: tb/tb_fifo36_wrr_sched.sv
// Directed bench for fifo36_wrr_sched: packet sources per input, an output
// beat log, and per-scenario tasks with hand-derived grant orders.
module tb_fifo36_wrr_sched;
   import fifo36_wrr_sched_pkg::*;

   logic        clk;
   logic        reset;
   logic        clear;
   logic [3:0]  weight0, weight1, weight2;
   logic [35:0] data0_i, data1_i, data2_i;
   logic        src0_rdy_i, src1_rdy_i, src2_rdy_i;
   logic        dst0_rdy_o, dst1_rdy_o, dst2_rdy_o;
   logic [35:0] data_o;
   logic        src_rdy_o;
   logic        dst_rdy_i;
   logic        active_o;
   logic [1:0]  grant_o;

   fifo36_wrr_sched #(.WEIGHT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .weight0    (weight0),
      .weight1    (weight1),
      .weight2    (weight2),
      .data0_i    (data0_i),
      .src0_rdy_i (src0_rdy_i),
      .dst0_rdy_o (dst0_rdy_o),
      .data1_i    (data1_i),
      .src1_rdy_i (src1_rdy_i),
      .dst1_rdy_o (dst1_rdy_o),
      .data2_i    (data2_i),
      .src2_rdy_i (src2_rdy_i),
      .dst2_rdy_o (dst2_rdy_o),
      .data_o     (data_o),
      .src_rdy_o  (src_rdy_o),
      .dst_rdy_i  (dst_rdy_i),
      .active_o   (active_o),
      .grant_o    (grant_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          src_pkt  [3];
   int          src_beat [3];
   int          src_len  [3];
   bit          en       [3];
   logic [35:0] out_q [$];
   logic [35:0] exp_q [$];
   int          seq_q [$];

   logic        obs_active;
   logic [1:0]  obs_grant;
   logic        obs_src_rdy;
   logic [35:0] obs_data;
   logic [2:0]  obs_dst;

   int n_checks = 0;
   int n_fail   = 0;

   // Word layout: [33]=EOF, [32]=SOF, [31:24]=source, [23:8]=packet, [7:0]=beat.
   function automatic logic [35:0] make_word(input int src, input int pkt,
                                             input int beat, input int len);
      logic [35:0] w;
      w = '0;
      w[31:24] = 8'(src);
      w[23:8]  = 16'(pkt);
      w[7:0]   = 8'(beat);
      w[SOF_BIT] = (beat == 0);
      w[EOF_BIT] = (beat == len - 1);
      w[OCC_MSB:OCC_LSB] = 2'b00;
      return w;
   endfunction

   task automatic drive();
      data0_i    = make_word(0, src_pkt[0], src_beat[0], src_len[0]);
      data1_i    = make_word(1, src_pkt[1], src_beat[1], src_len[1]);
      data2_i    = make_word(2, src_pkt[2], src_beat[2], src_len[2]);
      src0_rdy_i = en[0];
      src1_rdy_i = en[1];
      src2_rdy_i = en[2];
   endtask

   // One clock: sample at the falling edge, then advance sources after the rising edge.
   task automatic tick();
      bit xfer [3];
      bit flush;
      @(negedge clk);
      obs_active  = active_o;
      obs_grant   = grant_o;
      obs_src_rdy = src_rdy_o;
      obs_data    = data_o;
      obs_dst     = {dst2_rdy_o, dst1_rdy_o, dst0_rdy_o};
      if (src_rdy_o && dst_rdy_i) out_q.push_back(data_o);
      xfer[0] = src0_rdy_i & dst0_rdy_o;
      xfer[1] = src1_rdy_i & dst1_rdy_o;
      xfer[2] = src2_rdy_i & dst2_rdy_o;
      flush   = reset | clear;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (flush) begin
            src_beat[i] = 0;
         end else if (xfer[i]) begin
            src_beat[i]++;
            if (src_beat[i] == src_len[i]) begin
               src_beat[i] = 0;
               src_pkt[i]++;
            end
         end
      end
      drive();
   endtask

   task automatic start_test(input int w0, input int w1, input int w2, input int len,
                             input bit e0, input bit e1, input bit e2);
      weight0 = 4'(w0);
      weight1 = 4'(w1);
      weight2 = 4'(w2);
      for (int i = 0; i < 3; i++) begin
         src_pkt[i]  = 0;
         src_beat[i] = 0;
         src_len[i]  = len;
      end
      en[0] = e0;
      en[1] = e1;
      en[2] = e2;
      dst_rdy_i = 1'b1;
      out_q.delete();
      seq_q.delete();
      drive();
   endtask

   task automatic stop_sources();
      en[0] = 1'b0;
      en[1] = 1'b0;
      en[2] = 1'b0;
      drive();
   endtask

   // Expected output stream for the packet source order held in seq_q.
   task automatic build_exp(input int len);
      int cnt [3];
      cnt = '{0, 0, 0};
      exp_q.delete();
      foreach (seq_q[p]) begin
         for (int b = 0; b < len; b++)
            exp_q.push_back(make_word(seq_q[p], cnt[seq_q[p]], b, len));
         cnt[seq_q[p]]++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear = 1'b0;
      start_test(1, 1, 1, 3, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if (obs_active !== 1'b0) begin
            $display("FAIL reset_active: got %b want 0", obs_active);
            n_fail++;
         end
         n_checks++;
         if (obs_grant !== 2'd0) begin
            $display("FAIL reset_grant: got %0d want 0", obs_grant);
            n_fail++;
         end
         n_checks++;
         if (obs_src_rdy !== 1'b0 || obs_data !== 36'h0 || obs_dst !== 3'b000) begin
            $display("FAIL reset_outputs: src_rdy %b data %h dst %b want all zero",
                     obs_src_rdy, obs_data, obs_dst);
            n_fail++;
         end
      end
   endtask

   task automatic test_rr111();
      start_test(1, 1, 1, 3, 1, 1, 1);
      seq_q = '{0, 1, 2, 0, 1, 2};
      for (int c = 0; c < 24; c++) begin
         tick();
         n_checks++;
         if (obs_active !== (c % 4 != 0)) begin
            $display("FAIL rr111_active c=%0d: got %b want %b", c, obs_active, (c % 4 != 0));
            n_fail++;
         end
         if (c % 4 != 0) begin
            n_checks++;
            if (obs_grant !== 2'(seq_q[c / 4])) begin
               $display("FAIL rr111_grant c=%0d: got %0d want %0d", c, obs_grant, seq_q[c / 4]);
               n_fail++;
            end
         end else begin
            n_checks++;
            if (obs_src_rdy !== 1'b0 || obs_data !== 36'h0) begin
               $display("FAIL rr111_idle c=%0d: src_rdy %b data %h want 0", c, obs_src_rdy, obs_data);
               n_fail++;
            end
         end
      end
      stop_sources();
      build_exp(3);
      n_checks++;
      if (out_q.size() !== exp_q.size()) begin
         $display("FAIL rr111_count: got %0d beats want %0d", out_q.size(), exp_q.size());
         n_fail++;
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[k] !== exp_q[k]) begin
            $display("FAIL rr111_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            n_fail++;
         end
      end
   endtask

   task automatic test_weighted();
      start_test(3, 1, 1, 2, 1, 1, 1);
      seq_q = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
      for (int c = 0; c < 30; c++) begin
         tick();
         n_checks++;
         if (obs_active !== (c % 3 != 0)) begin
            $display("FAIL weighted_active c=%0d: got %b want %b", c, obs_active, (c % 3 != 0));
            n_fail++;
         end
         if (c % 3 != 0) begin
            n_checks++;
            if (obs_grant !== 2'(seq_q[c / 3])) begin
               $display("FAIL weighted_grant c=%0d: got %0d want %0d", c, obs_grant, seq_q[c / 3]);
               n_fail++;
            end
         end
      end
      stop_sources();
      build_exp(2);
      n_checks++;
      if (out_q.size() !== exp_q.size()) begin
         $display("FAIL weighted_count: got %0d beats want %0d", out_q.size(), exp_q.size());
         n_fail++;
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[k] !== exp_q[k]) begin
            $display("FAIL weighted_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            n_fail++;
         end
      end
   endtask

   task automatic test_single_requester();
      start_test(0, 2, 1, 3, 0, 1, 0);
      seq_q = '{1, 1, 1, 1};
      for (int c = 0; c < 16; c++) begin
         tick();
         n_checks++;
         if (obs_active !== (c % 4 != 0)) begin
            $display("FAIL single_active c=%0d: got %b want %b", c, obs_active, (c % 4 != 0));
            n_fail++;
         end
         if (c >= 1) begin
            n_checks++;
            if (obs_grant !== 2'd1) begin
               $display("FAIL single_grant c=%0d: got %0d want 1", c, obs_grant);
               n_fail++;
            end
         end
      end
      stop_sources();
      build_exp(3);
      n_checks++;
      if (out_q.size() !== exp_q.size()) begin
         $display("FAIL single_count: got %0d beats want %0d", out_q.size(), exp_q.size());
         n_fail++;
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[k] !== exp_q[k]) begin
            $display("FAIL single_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            n_fail++;
         end
      end
   endtask

   task automatic test_weight_zero();
      start_test(1, 1, 0, 2, 1, 0, 1);
      seq_q = '{0, 0, 0};
      for (int c = 0; c < 9; c++) begin
         tick();
         n_checks++;
         if (obs_dst[2] !== 1'b0) begin
            $display("FAIL wzero_dst2 c=%0d: got %b want 0", c, obs_dst[2]);
            n_fail++;
         end
         if (c % 3 != 0) begin
            n_checks++;
            if (obs_grant !== 2'd0 || obs_active !== 1'b1) begin
               $display("FAIL wzero_grant c=%0d: grant %0d active %b want 0/1", c, obs_grant, obs_active);
               n_fail++;
            end
         end
      end
      stop_sources();
      build_exp(2);
      n_checks++;
      if (out_q.size() !== exp_q.size()) begin
         $display("FAIL wzero_count: got %0d beats want %0d", out_q.size(), exp_q.size());
         n_fail++;
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[k] !== exp_q[k]) begin
            $display("FAIL wzero_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            n_fail++;
         end
      end
   endtask

   task automatic test_single_beat();
      start_test(1, 1, 1, 1, 1, 1, 1);
      seq_q = '{1, 2, 0, 1, 2, 0};
      for (int c = 0; c < 12; c++) begin
         tick();
         n_checks++;
         if (obs_active !== (c % 2 != 0)) begin
            $display("FAIL sbeat_active c=%0d: got %b want %b", c, obs_active, (c % 2 != 0));
            n_fail++;
         end
      end
      stop_sources();
      build_exp(1);
      n_checks++;
      if (out_q.size() !== exp_q.size()) begin
         $display("FAIL sbeat_count: got %0d beats want %0d", out_q.size(), exp_q.size());
         n_fail++;
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[k] !== exp_q[k]) begin
            $display("FAIL sbeat_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            n_fail++;
         end
      end
   endtask

   task automatic test_backpressure();
      start_test(1, 1, 1, 4, 1, 0, 0);
      seq_q = '{0};
      tick();
      tick();
      tick();
      dst_rdy_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (obs_data !== make_word(0, 0, 2, 4) || obs_src_rdy !== 1'b1) begin
            $display("FAIL bp_hold c=%0d: data %h src_rdy %b want %h/1",
                     c, obs_data, obs_src_rdy, make_word(0, 0, 2, 4));
            n_fail++;
         end
         n_checks++;
         if (obs_grant !== 2'd0 || obs_active !== 1'b1) begin
            $display("FAIL bp_grant c=%0d: grant %0d active %b want 0/1", c, obs_grant, obs_active);
            n_fail++;
         end
      end
      dst_rdy_i = 1'b1;
      tick();
      tick();
      stop_sources();
      tick();
      n_checks++;
      if (obs_active !== 1'b0) begin
         $display("FAIL bp_idle: active got %b want 0", obs_active);
         n_fail++;
      end
      build_exp(4);
      n_checks++;
      if (out_q.size() !== exp_q.size()) begin
         $display("FAIL bp_count: got %0d beats want %0d", out_q.size(), exp_q.size());
         n_fail++;
      end
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[k] !== exp_q[k]) begin
            $display("FAIL bp_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
            n_fail++;
         end
      end
   endtask

   task automatic test_clear();
      start_test(1, 1, 1, 4, 1, 0, 0);
      tick();
      tick();
      tick();
      clear = 1'b1;
      en[1] = 1'b1;
      en[2] = 1'b1;
      drive();
      tick();
      n_checks++;
      if (obs_data !== make_word(0, 0, 2, 4)) begin
         $display("FAIL clear_beat2: got %h want %h", obs_data, make_word(0, 0, 2, 4));
         n_fail++;
      end
      clear = 1'b0;
      tick();
      n_checks++;
      if (obs_active !== 1'b0 || obs_src_rdy !== 1'b0 || obs_dst !== 3'b000) begin
         $display("FAIL clear_flush: active %b src_rdy %b dst %b want 0/0/000",
                  obs_active, obs_src_rdy, obs_dst);
         n_fail++;
      end
      tick();
      n_checks++;
      if (obs_active !== 1'b1 || obs_grant !== 2'd0) begin
         $display("FAIL clear_regrant: active %b grant %0d want 1/0", obs_active, obs_grant);
         n_fail++;
      end
      n_checks++;
      if (obs_data !== make_word(0, 0, 0, 4) || obs_src_rdy !== 1'b1) begin
         $display("FAIL clear_sof: data %h src_rdy %b want %h/1",
                  obs_data, obs_src_rdy, make_word(0, 0, 0, 4));
         n_fail++;
      end
      stop_sources();
   endtask

   initial begin
      test_reset();
      test_rr111();
      test_weighted();
      test_single_requester();
      test_weight_zero();
      test_single_beat();
      test_backpressure();
      test_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
